// File: rtl/hmc_rx_flit_packer.sv
// Packs a one-flit-per-cycle stream into FPW-flit PHY words, with optional
// per-packet padding, idle-timeout flush of partial words and null-slot counting.
module hmc_rx_flit_packer #(
   parameter int FPW           = 4,
   parameter int FLIT_SIZE     = 128,
   parameter int DWIDTH        = FPW*FLIT_SIZE,
   parameter int PAD_MODE      = 1,
   parameter int FLUSH_TIMEOUT = 16
) (
   input  logic                 clk,
   input  logic                 res_n,
   input  logic [FLIT_SIZE-1:0] flit_data,
   input  logic                 flit_valid,
   input  logic                 flit_eop,
   output logic                 flit_ready,
   output logic [DWIDTH-1:0]    phy_data,
   output logic                 phy_valid,
   input  logic                 phy_ready,
   output logic [FPW-1:0]       phy_flit_mask,
   output logic [FPW-1:0]       phy_eop_mask,
   output logic [15:0]          null_flit_cnt
);

   localparam int IDXW = (FPW > 1) ? $clog2(FPW) : 1;
   localparam int IDLW = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(FPW - 1);
   localparam logic [IDLW-1:0] IDLE_MAX = IDLW'(FLUSH_TIMEOUT);

   logic [DWIDTH-1:0] acc_data;
   logic [DWIDTH-1:0] word_data;
   logic [FPW-1:0]    acc_eop;
   logic [FPW-1:0]    word_eop;
   logic [FPW-1:0]    word_fill;
   logic [IDXW-1:0]   idx;
   logic [IDXW:0]     n_fill;
   logic [IDLW-1:0]   idle_cnt;
   logic              out_free;
   logic              accept;
   logic              close_acc;
   logic              flush;
   logic              close_word;

   assign out_free   = !phy_valid || phy_ready;
   assign flit_ready = out_free;
   assign accept     = flit_valid && out_free;
   assign close_acc  = accept && ((idx == IDX_LAST) || ((PAD_MODE != 0) && flit_eop));
   // An accept in the same cycle always beats the timeout.
   assign flush      = (FLUSH_TIMEOUT > 0) && !accept && (idx != '0) &&
                       (idle_cnt == IDLE_MAX) && out_free;
   assign close_word = close_acc || flush;

   // Candidate word: the assembly buffer plus the flit being accepted now.
   always_comb begin
      word_data = acc_data;
      word_eop  = acc_eop;
      n_fill    = {1'b0, idx};
      if (accept) begin
         word_data[int'(idx)*FLIT_SIZE +: FLIT_SIZE] = flit_data;
         word_eop[idx] = flit_eop;
         n_fill        = {1'b0, idx} + (IDXW+1)'(1);
      end
      for (int i = 0; i < FPW; i++) begin
         word_fill[i] = (i < int'(n_fill));
      end
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         phy_valid     <= 1'b0;
         phy_data      <= '0;
         phy_flit_mask <= '0;
         phy_eop_mask  <= '0;
         null_flit_cnt <= '0;
         acc_data      <= '0;
         acc_eop       <= '0;
         idx           <= '0;
         idle_cnt      <= '0;
      end else begin
         if (close_word) begin
            phy_valid     <= 1'b1;
            phy_data      <= word_data;
            phy_flit_mask <= word_fill;
            phy_eop_mask  <= word_eop;
            null_flit_cnt <= null_flit_cnt + 16'(FPW - int'(n_fill));
            acc_data      <= '0;
            acc_eop       <= '0;
            idx           <= '0;
         end else begin
            if (phy_ready) phy_valid <= 1'b0;
            if (accept) begin
               acc_data <= word_data;
               acc_eop  <= word_eop;
               idx      <= idx + IDXW'(1);
            end
         end

         if (accept || (idx == '0) || flush) begin
            idle_cnt <= '0;
         end else if ((FLUSH_TIMEOUT > 0) && (idle_cnt != IDLE_MAX)) begin
            idle_cnt <= idle_cnt + IDLW'(1);
         end
      end
   end

endmodule

// File: doc/hmc_rx_flit_packer.md
Name: hmc_rx_flit_packer

Overview:
- Synthesizable successor to the HMC agent's response-driving path on the RX PHY side.
- Accepts a flit stream, one flit per cycle with end-of-packet marking, and packs it into FPW-flit PHY words for phy_data_rx_phy2link-style buses.
- Generalised in FPW, FLIT_SIZE and packing mode; adds backpressure, partial-word timeout flush, per-slot valid/EOP masks and a null-flit counter.
- Sits between the response generator and the link RX PHY interface.

Parameters:
- FPW, 4, flits per PHY word (power of 2, 2..8).
- FLIT_SIZE, 128, bits per flit.
- DWIDTH, FPW*FLIT_SIZE, PHY word width (derived; do not override).
- PAD_MODE, 1, 1 = each packet is padded with null flits to a word boundary; 0 = dense, so a packet may start mid-word.
- FLUSH_TIMEOUT, 16, idle cycles before a partial word is flushed; 0 disables flushing.

Ports:
- clk  input  1  clock
- res_n  input  1  asynchronous active-low reset
- flit_data  input  FLIT_SIZE  incoming flit
- flit_valid  input  1  flit_data valid
- flit_eop  input  1  flit is the last flit of its packet
- flit_ready  output  1  block can accept a flit this cycle
- phy_data  output  DWIDTH  packed word; slot i occupies [(i+1)*FLIT_SIZE-1 : i*FLIT_SIZE], slot 0 holds the first flit
- phy_valid  output  1  phy_data valid
- phy_ready  input  1  consumer takes the word
- phy_flit_mask  output  FPW  bit i = slot i carries a real flit
- phy_eop_mask  output  FPW  bit i = slot i carries an EOP flit
- null_flit_cnt  output  16  total padded (null) slots emitted, wraps

Behaviour:
- Storage:
  - Assembly buffer acc[FPW] with per-slot eop bits.
  - Fill index idx, 0..FPW-1.
  - Output register holding phy_data and the two masks.
  - Idle counter idle_cnt.
- Reset (async, res_n=0):
  - phy_valid=0, phy_data=0, both masks=0, null_flit_cnt=0.
  - idx=0, idle_cnt=0, acc cleared.
  - A partial word in flight at reset is discarded.
- Output register state:
  - "free" when phy_valid=0 or phy_ready=1 in the same cycle.
  - flit_ready = free (combinational from phy_valid/phy_ready).
- Accept: flit_valid & flit_ready. The flit is written to slot idx; its eop bit is recorded.
- Word close on an accepted flit, when any of:
  - idx==FPW-1;
  - PAD_MODE=1 and flit_eop=1.
- On word close:
  - Next cycle, phy_data carries acc including the new flit; unfilled slots are zero.
  - phy_flit_mask has bits 0..idx set; phy_eop_mask carries the recorded eop bits.
  - idx returns to 0; phy_valid=1.
  - null_flit_cnt += FPW-1-idx.
- Latency: exactly one cycle from the accept of the closing flit to phy_valid.
- Non-closing accept: idx increments; no output change.
- Output hold: phy_valid remains 1 and phy_data/masks remain stable until phy_ready=1.
  - Handshake cycle with no new close: phy_valid goes to 0 next cycle.
  - Handshake cycle with a close: the new word loads, giving back-to-back words with no bubble.
- Timeout flush (FLUSH_TIMEOUT>0):
  - idle_cnt counts cycles with idx!=0 and no accept; it clears on any accept or when idx==0.
  - When idle_cnt==FLUSH_TIMEOUT and the output is free, the partial word closes as above (zero padding, masks, counter update) and idle_cnt clears.
  - If the output is not free, the flush waits until it is. idle_cnt saturates at FLUSH_TIMEOUT meanwhile.
- Simultaneous accept and timeout: the accept wins. The flit is stored and idle_cnt clears; the flush does not occur that cycle.
- PAD_MODE=0: a packet boundary never closes a word. An EOP in slot k and the next packet's SOP in slot k+1 share one word. Only a full word or a timeout closes it.
- A flit arriving with flit_ready=0 is not consumed; the source holds it.
- null_flit_cnt wraps from 16'hFFFF to 0.

Test Plan:
1. FPW=4, PAD_MODE=1: one 4-flit packet A0..A3, eop on A3, phy_ready=1 -> one cycle after the A3 accept, phy_data={A3,A2,A1,A0}, flit_mask=4'b1111, eop_mask=4'b1000, null_flit_cnt=0.
2. PAD_MODE=1: 1-flit packet B0 (eop) then 6-flit packet C0..C5 -> three words:
   - {0,0,0,B0}, flit_mask 0001, eop_mask 0001;
   - {C3..C0}, flit_mask 1111, eop_mask 0000;
   - {0,0,C5,C4}, flit_mask 0011, eop_mask 0010;
   - null_flit_cnt=5.
3. PAD_MODE=0: packets of 3, 2 and 3 flits back-to-back -> exactly two full words with flit_mask 1111. eop_mask is 0100 for word 1 and 1001 for word 2. null_flit_cnt=0.
4. Backpressure: phy_ready=0 for 5 cycles while a word is pending -> flit_ready=0 and phy_data stable. phy_ready=1 -> the next word follows on the next cycle with no bubble and no flit lost or duplicated.
5. Timeout, FLUSH_TIMEOUT=16, PAD_MODE=0: 2 flits (no eop), then idle -> a word is emitted on the 17th cycle after the last accept with flit_mask 0011 and null_flit_cnt +2. A variant with a flit on idle cycle 16 -> no flush and the flit goes to slot 2.
6. Reset mid-word: 3 flits accepted, then res_n pulsed low asynchronously between clock edges -> phy_valid=0 immediately. After release, the next 4 flits form a word from slot 0 and no stale data appears.
